oled_spi_receiver: RTL
======================

Name: oled_spi_receiver

Overview:
- Receive-side model of the PmodOLEDrgb (SSD1331) 4-wire SPI link.
- Oversamples cs/sclk/sdin/d_cn/resn in the system clock domain and reassembles bytes. Decodes the column-window (0x15) and row-window (0x75) commands and turns data-byte pairs into addressed RGB565 pixel writes.
- Used as a loopback checker and mirror-framebuffer writer for the display driver's JB outputs.

Parameters:
- WIDTH, 96, display columns.
- HEIGHT, 64, display rows.
- SYNC_STAGES, 2, flip-flop stages on each SPI input (minimum 2).

Ports:
- clk  in  1  system clock (100 MHz basys_clock); must be ≥4× sclk frequency.
- reset  in  1  synchronous, active-high reset.
- cs  in  1  SPI chip select, active low.
- sclk  in  1  SPI clock; idle high; data sampled on rising edge.
- sdin  in  1  SPI data, MSB first.
- d_cn  in  1  1 = data byte, 0 = command/parameter byte.
- resn  in  1  display reset, active low; acts as soft reset.
- byte_valid  out  1  one-cycle strobe when a byte completes.
- byte_data  out  8  completed byte.
- byte_is_data  out  1  d_cn value captured at the 8th bit.
- pix_valid  out  1  one-cycle strobe on each completed pixel.
- pix_x  out  7  column of the pixel.
- pix_y  out  6  row of the pixel.
- pix_index  out  13  pix_y*WIDTH+pix_x, range 0..6143.
- pix_data  out  16  RGB565 value {high byte, low byte}.

Behaviour:
- Reset: when reset=1, or the synchronised resn=0, on any clk edge:
  - all outputs go to 0;
  - bit counter, byte phase and FSM are cleared;
  - window is col 0..95, row 0..63;
  - cursor is (0,0).
  - Synchroniser flops hold their last value and are not cleared.
- Input path: each SPI input passes through SYNC_STAGES flops. A rising edge of sclk is detected when the previous synchronised value is 0 and the current one is 1.
- Deassertion: synchronised cs=1 clears the bit counter and the pixel byte phase. Any partial byte is discarded without a strobe. FSM state and cursor are kept.
- Bit shift: on an sclk rising edge with cs=0, sdin shifts into the LSB, so the first bit received ends up as the MSB.
- Byte completion: on the 8th bit, byte_valid=1 for exactly one clk.
  - byte_data holds the new byte and byte_is_data holds d_cn sampled on that same edge.
  - The bit counter wraps to 0, so back-to-back bytes with cs held low are legal.
  - Latency from the 8th sclk rising edge at the pins to byte_valid is SYNC_STAGES+1 clk.
- Command FSM (advances only on command bytes, byte_is_data=0):
  - CMD: byte 0x15 → COL_S; byte 0x75 → ROW_S; any other value → stay in CMD (byte is reported only).
  - COL_S: col_start = byte clamped to WIDTH-1 → COL_E.
  - COL_E: col_end = byte clamped to WIDTH-1; if col_end < col_start then col_end = col_start; cursor x = col_start → CMD.
  - ROW_S / ROW_E: same as the column states using HEIGHT-1; cursor y = row_start → CMD.
  - A data byte arriving while not in CMD aborts the pending parameter sequence: FSM returns to CMD, the window is unchanged, and the byte is processed as pixel data.
- Pixel assembly (data bytes only):
  - phase 0: latch the high byte, phase becomes 1.
  - phase 1: pix_valid=1 for one clk with pix_data={hi, byte}, pix_x/pix_y set to the cursor, and pix_index computed from them; phase becomes 0.
  - pix_valid is asserted in the same cycle as byte_valid for the low byte.
  - A command byte arriving at phase 1 clears phase to 0; the latched high byte is dropped.
- Cursor advance, applied after each pixel:
  - x == col_end → x = col_start and y increments;
  - y == row_end at that point → y = row_start (window wrap);
  - otherwise x increments.
- pix_x, pix_y, pix_index and pix_data hold their values between strobes; only the strobes pulse.
- Arithmetic: pix_index = (pix_y<<6) + (pix_y<<5) + pix_x, zero-extended to 13 bits; no multiplier is required.

Decomposition:
- Shared package (oled_pkg):
  - OLED_WIDTH=96 and OLED_HEIGHT=64;
  - CMD_SET_COL=8'h15 and CMD_SET_ROW=8'h75;
  - FSM state enum {CMD, COL_S, COL_E, ROW_S, ROW_E}.
- One sub-module, spi_byte_rx: synchronisers, edge detect, shift register and bit counter. It outputs byte_valid, byte_data and byte_is_data.
- The top module holds the FSM, window registers, pixel assembly and cursor logic.

Test Plan:
- Byte capture: cs=0, send 0xA5 with d_cn=0 at sclk = clk/8 → one byte_valid, byte_data=0xA5, byte_is_data=0, no pix_valid.
- Default window: send data 0xF8,0x00 then 0x07,0xE0 → pix_valid #1 (x=0, y=0, index=0, data=0xF800); #2 (x=1, y=0, index=1, data=0x07E0).
- Window and wrap: commands 0x15,10,11,0x75,5,6, then 5 pixels → (x,y) sequence (10,5), (11,5), (10,6), (11,6), (10,5); index of (11,6) is 587.
- Clamping: commands 0x15,200,3 → col_start=95, col_end=95; the next pixels all have x=95.
- Aborts and drops:
  - cs raised after 5 bits, then a full 0x3C → only byte 0x3C is reported.
  - Data 0xAA, command 0x00, data 0x12,0x34 → one pixel, data 0x1234.
- Reset and full frame:
  - resn pulsed low after a window change → window returns to 0..95/0..63, cursor to (0,0).
  - 6144 full-frame pixels → last pixel index 6143, the next pixel index 0.

Source files
------------

// File: rtl/oled_pkg.sv
// Shared constants and types for the PmodOLEDrgb (SSD1331) SPI receive model.
package oled_pkg;

  localparam int OLED_WIDTH  = 96;
  localparam int OLED_HEIGHT = 64;

  localparam logic [7:0] CMD_SET_COL = 8'h15;
  localparam logic [7:0] CMD_SET_ROW = 8'h75;

  typedef enum logic [2:0] {
    CMD,
    COL_S,
    COL_E,
    ROW_S,
    ROW_E
  } cmd_state_t;

endpackage

// File: rtl/spi_byte_rx.sv
// Oversampling SPI byte receiver: synchronises the link pins into the clk
// domain, detects sclk rising edges and reassembles MSB-first bytes.
module spi_byte_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       sclk,
  input  logic       sdin,
  input  logic       d_cn,
  input  logic       resn,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_is_data,
  output logic       cs_idle,
  output logic       clear
);

  logic [SYNC_STAGES-1:0] cs_p0;
  logic [SYNC_STAGES-1:0] sclk_p0;
  logic [SYNC_STAGES-1:0] sdin_p0;
  logic [SYNC_STAGES-1:0] dcn_p0;
  logic [SYNC_STAGES-1:0] resn_p0;
  logic                   sclk_prev_p1;
  logic [6:0]             shift_p1;
  logic [2:0]             bit_cnt;
  logic                   sclk_rise;
  logic                   sdin_s;

  // Synchroniser chains; intentionally never reset so they track the pins
  always_ff @(posedge clk) begin
    cs_p0        <= {cs_p0[SYNC_STAGES-2:0], cs};
    sclk_p0      <= {sclk_p0[SYNC_STAGES-2:0], sclk};
    sdin_p0      <= {sdin_p0[SYNC_STAGES-2:0], sdin};
    dcn_p0       <= {dcn_p0[SYNC_STAGES-2:0], d_cn};
    resn_p0      <= {resn_p0[SYNC_STAGES-2:0], resn};
    sclk_prev_p1 <= sclk_p0[SYNC_STAGES-1];
  end

  // ---- stage boundary: synchronised pins -> edge detect / shift ----
  assign clear     = reset | ~resn_p0[SYNC_STAGES-1];
  assign cs_idle   = cs_p0[SYNC_STAGES-1];
  assign sdin_s    = sdin_p0[SYNC_STAGES-1];
  assign sclk_rise = sclk_p0[SYNC_STAGES-1] & ~sclk_prev_p1;

  // Shift register and bit counter; a raised cs discards any partial byte
  always_ff @(posedge clk) begin
    if (clear) begin
      bit_cnt      <= 3'd0;
      shift_p1     <= 7'd0;
      byte_valid   <= 1'b0;
      byte_data    <= 8'd0;
      byte_is_data <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (cs_idle) begin
        bit_cnt <= 3'd0;
      end else if (sclk_rise) begin
        shift_p1 <= {shift_p1[5:0], sdin_s};
        if (bit_cnt == 3'd7) begin
          bit_cnt      <= 3'd0;
          byte_valid   <= 1'b1;
          byte_data    <= {shift_p1, sdin_s};
          byte_is_data <= dcn_p0[SYNC_STAGES-1];
        end else begin
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/oled_spi_receiver.sv
// SSD1331 receive-side model: decodes column/row window commands and turns
// data-byte pairs into addressed RGB565 pixel writes.
module oled_spi_receiver
  import oled_pkg::*;
#(
  parameter int WIDTH       = OLED_WIDTH,
  parameter int HEIGHT      = OLED_HEIGHT,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        sclk,
  input  logic        sdin,
  input  logic        d_cn,
  input  logic        resn,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        byte_is_data,
  output logic        pix_valid,
  output logic [6:0]  pix_x,
  output logic [5:0]  pix_y,
  output logic [12:0] pix_index,
  output logic [15:0] pix_data
);

  cmd_state_t  state;
  logic        clear;
  logic        cs_idle;
  logic [6:0]  col_start, col_end, cur_x, x_q;
  logic [5:0]  row_start, row_end, cur_y, y_q;
  logic [7:0]  hi_byte;
  logic [15:0] data_q;
  logic        phase;
  logic        pix_fire;
  logic [6:0]  col_cl;
  logic [5:0]  row_cl;

  function automatic logic [6:0] clamp_col(input logic [7:0] b);
    if (b > 8'(WIDTH - 1)) return 7'(WIDTH - 1);
    return b[6:0];
  endfunction

  function automatic logic [5:0] clamp_row(input logic [7:0] b);
    if (b > 8'(HEIGHT - 1)) return 6'(HEIGHT - 1);
    return b[5:0];
  endfunction

  spi_byte_rx #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rx (
    .clk         (clk),
    .reset       (reset),
    .cs          (cs),
    .sclk        (sclk),
    .sdin        (sdin),
    .d_cn        (d_cn),
    .resn        (resn),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_is_data(byte_is_data),
    .cs_idle     (cs_idle),
    .clear       (clear)
  );

  // ---- stage boundary: completed byte -> command decode / pixel assembly ----
  assign col_cl   = clamp_col(byte_data);
  assign row_cl   = clamp_row(byte_data);
  assign pix_fire = byte_valid & byte_is_data & phase;

  // Pixel strobe coincides with the low byte; coordinates hold between strobes
  assign pix_valid = pix_fire;
  assign pix_x     = pix_fire ? cur_x : x_q;
  assign pix_y     = pix_fire ? cur_y : y_q;
  assign pix_data  = pix_fire ? {hi_byte, byte_data} : data_q;
  assign pix_index = ({7'd0, pix_y} << 6) + ({7'd0, pix_y} << 5) + {6'd0, pix_x};

  // Command FSM, window registers, pixel byte phase and cursor walk
  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= CMD;
      col_start <= 7'd0;
      col_end   <= 7'(WIDTH - 1);
      row_start <= 6'd0;
      row_end   <= 6'(HEIGHT - 1);
      cur_x     <= 7'd0;
      cur_y     <= 6'd0;
      x_q       <= 7'd0;
      y_q       <= 6'd0;
      data_q    <= 16'd0;
      hi_byte   <= 8'd0;
      phase     <= 1'b0;
    end else if (byte_valid) begin
      if (byte_is_data) begin
        // A data byte also abandons any half-entered window command
        state <= CMD;
        if (!phase) begin
          hi_byte <= byte_data;
          phase   <= 1'b1;
        end else begin
          phase  <= 1'b0;
          x_q    <= cur_x;
          y_q    <= cur_y;
          data_q <= {hi_byte, byte_data};
          if (cur_x == col_end) begin
            cur_x <= col_start;
            cur_y <= (cur_y == row_end) ? row_start : cur_y + 6'd1;
          end else begin
            cur_x <= cur_x + 7'd1;
          end
        end
      end else begin
        phase <= 1'b0;
        case (state)
          CMD: begin
            if (byte_data == CMD_SET_COL)      state <= COL_S;
            else if (byte_data == CMD_SET_ROW) state <= ROW_S;
          end
          COL_S: begin
            col_start <= col_cl;
            state     <= COL_E;
          end
          COL_E: begin
            col_end <= (col_cl < col_start) ? col_start : col_cl;
            cur_x   <= col_start;
            state   <= CMD;
          end
          ROW_S: begin
            row_start <= row_cl;
            state     <= ROW_E;
          end
          ROW_E: begin
            row_end <= (row_cl < row_start) ? row_start : row_cl;
            cur_y   <= row_start;
            state   <= CMD;
          end
          default: state <= CMD;
        endcase
      end
    end else if (cs_idle) begin
      phase <= 1'b0;
    end
  end

endmodule
